sha2_msg_sched: RTL
===================

// Module: sha2_msg_sched
// PURPOSE
//  Streaming SHA-2 message schedule generator, successor to the fixed SHA-256 rME block.
//  - Input: one 16-word block, loaded serially over a valid/ready port.
//  - Output: the full W[t] sequence, one word per handshake, with consumer backpressure.
//  - DATA_WIDTH selects the variant: 32 gives SHA-256 (64 rounds), 64 gives SHA-512 (80 rounds).
//  - Sits between the padding/block buffer and the compression round engine.
// PARAMETERS
//  DATA_WIDTH  32  word width; legal values 32 or 64 only; any other value is an elaboration error
//  ROUNDS      derived localparam, not overridable: 64 when DATA_WIDTH=32, 80 when DATA_WIDTH=64
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           synchronous active-low reset
//  i_abort       in   1           synchronous abort; returns the block to IDLE
//  i_word        in   DATA_WIDTH  message word M[k], big-endian order, k=0 first
//  i_word_valid  in   1           i_word is valid
//  o_word_ready  out  1           block accepts a message word this cycle
//  o_w           out  DATA_WIDTH  schedule word W[o_round]
//  o_w_valid     out  1           o_w and o_round are valid
//  i_w_ready     in   1           consumer accepts o_w this cycle
//  o_round       out  7           round index t of o_w, range 0..ROUNDS-1
//  o_FSM_state   out  2           current state: 00 IDLE, 01 LOAD, 10 EXPAND, 11 DONE
//  o_done        out  1           one-cycle pulse, asserted in DONE
// BEHAVIOUR
//  Reset: sampled on clk while rst_n=0. All outputs go to 0; state IDLE; 16-word window cleared; counters cleared.
//  Window: 16-entry register file w[0..15].
//  IDLE:
//    - o_word_ready=1.
//    - An accepted word (valid&ready) is written to w[0], load count becomes 1, next state LOAD.
//  LOAD:
//    - o_word_ready=1.
//    - The k-th accepted word is written to w[k].
//    - When word 15 is accepted: next state EXPAND, o_round=0.
//    - No timeout; gaps in i_word_valid are allowed.
//  EXPAND:
//    - o_word_ready=0, o_w_valid=1.
//    - o_w=w[0]: direct register output, no combinational path from inputs.
//    - On o_w_valid&i_w_ready: window shifts w[i]<=w[i+1] for i=0..14, and
//      w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0]  (mod 2^DATA_WIDTH). Then o_round increments.
//    - i_w_ready=0 holds o_w, o_round and the window unchanged.
//    - Handshake at o_round=ROUNDS-1: next state DONE.
//  Sigma functions (ROTR = rotate right, SHR = shift right):
//    - 32-bit: s0 = ROTR7 ^ ROTR18 ^ SHR3;  s1 = ROTR17 ^ ROTR19 ^ SHR10.
//    - 64-bit: s0 = ROTR1 ^ ROTR8 ^ SHR7;   s1 = ROTR19 ^ ROTR61 ^ SHR6.
//  DONE:
//    - o_done=1, o_w_valid=0, o_word_ready=0, for exactly one cycle.
//    - Next state IDLE. The next block may start loading in the following cycle.
//  Latency:
//    - W[0] is valid in the cycle after the 16th word is accepted.
//    - With no stall, the last word is valid ROUNDS-1 cycles after W[0].
//  Abort:
//    - i_abort=1 in any state forces IDLE next cycle. Load count and o_round clear; o_w_valid drops.
//    - A word offered in the same cycle as the abort is discarded.
//    - rst_n has priority over i_abort.
//  Mid-block reset: identical to power-on reset, no partial output afterwards.
//  o_round is 0 outside EXPAND.
// STRUCTURE
//  sha2_pkg holds:
//    - state encodings ST_IDLE..ST_DONE;
//    - ROUNDS_256=64 and ROUNDS_512=80;
//    - rotate/shift constants for both widths.
//  Sub-module sha2_small_sigma #(DATA_WIDTH, SEL): combinational s0/s1; instantiated twice.
//  The 4-input adder is a single combinational stage; no extra pipeline register.
// TESTING
//  1. Pass-through:
//     - Stimulus: load 0x11111111..0xFFFFFFFF, 0x12345678 with width 32, i_w_ready=1.
//     - Response: rounds 0..15 equal the inputs in order; o_round counts 0..15.
//  2. SHA-256 "abc":
//     - Stimulus: W0=0x61626380, W1..W14=0, W15=0x00000018.
//     - Response: W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6.
//     - Also: o_done pulses once after round 63.
//  3. SHA-512 "abc" (width 64):
//     - Stimulus: W0=0x6162638000000000, W15=0x18, other words 0.
//     - Response: W16=0x6162638000000000, W17=0x00030000000000C0.
//     - Also: the last word has o_round=79.
//  4. Backpressure:
//     - Stimulus: random i_w_ready and random gaps in i_word_valid during test 2.
//     - Response: identical W sequence; o_w stable while stalled; no round skipped or repeated.
//  5. Abort / reset:
//     - Abort at load word 7; reset at round 30.
//     - Response: next cycle IDLE with all outputs 0; a following full block gives correct W.
//  6. Back-to-back blocks:
//     - Stimulus: second block offered while in DONE.
//     - Response: accepted in the cycle after DONE; no words from the first block leak into the second.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 message schedule: state encodings, round counts
// and the small-sigma rotate/shift amounts for both word widths.
package sha2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_EXPAND = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  // sigma0 / sigma1 amounts: two rotations then one logical shift
  localparam int S0_ROT_A_256 = 7;
  localparam int S0_ROT_B_256 = 18;
  localparam int S0_SHR_256   = 3;
  localparam int S1_ROT_A_256 = 17;
  localparam int S1_ROT_B_256 = 19;
  localparam int S1_SHR_256   = 10;

  localparam int S0_ROT_A_512 = 1;
  localparam int S0_ROT_B_512 = 8;
  localparam int S0_SHR_512   = 7;
  localparam int S1_ROT_A_512 = 19;
  localparam int S1_ROT_B_512 = 61;
  localparam int S1_SHR_512   = 6;

endpackage

// File: rtl/sha2_small_sigma.sv
// Combinational SHA-2 small sigma: SEL=0 gives sigma0, SEL=1 gives sigma1,
// with amounts chosen by DATA_WIDTH (32 = SHA-256, 64 = SHA-512).
module sha2_small_sigma
  import sha2_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL        = 0
) (
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);

  localparam bit WIDE = (DATA_WIDTH == 64);
  localparam int ROT_A = WIDE ? ((SEL == 0) ? S0_ROT_A_512 : S1_ROT_A_512)
                              : ((SEL == 0) ? S0_ROT_A_256 : S1_ROT_A_256);
  localparam int ROT_B = WIDE ? ((SEL == 0) ? S0_ROT_B_512 : S1_ROT_B_512)
                              : ((SEL == 0) ? S0_ROT_B_256 : S1_ROT_B_256);
  localparam int SHR   = WIDE ? ((SEL == 0) ? S0_SHR_512 : S1_SHR_512)
                              : ((SEL == 0) ? S0_SHR_256 : S1_SHR_256);

  function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] v, input int r);
    return (v >> r) | (v << (DATA_WIDTH - r));
  endfunction

  assign y = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ (x >> SHR);

endmodule

// File: rtl/sha2_msg_sched.sv
// Streaming SHA-2 message schedule: loads a 16-word block serially, then emits
// W[0..ROUNDS-1] one word per handshake from a sliding 16-entry window.
module sha2_msg_sched
  import sha2_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  output logic [DATA_WIDTH-1:0] o_w,
  output logic                  o_w_valid,
  input  logic                  i_w_ready,
  output logic [6:0]            o_round,
  output logic [1:0]            o_FSM_state,
  output logic                  o_done
);

  localparam int         ROUNDS     = (DATA_WIDTH == 64) ? ROUNDS_512 : ROUNDS_256;
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $error("sha2_msg_sched: DATA_WIDTH must be 32 or 64");
    end
  endgenerate

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] win [16];
  logic [3:0]            load_cnt;
  logic [6:0]            round;
  logic                  word_ready;
  logic                  word_acc;
  logic                  w_hs;
  logic                  expand;
  logic [DATA_WIDTH-1:0] s0, s1, w_next;

  sha2_small_sigma #(.DATA_WIDTH(DATA_WIDTH), .SEL(0)) u_s0 (.x(win[1]),  .y(s0));
  sha2_small_sigma #(.DATA_WIDTH(DATA_WIDTH), .SEL(1)) u_s1 (.x(win[14]), .y(s1));

  // win[0] holds W[t-16], so the new tail is W[t] for t = round + 16
  assign w_next   = s1 + win[9] + s0 + win[0];
  assign expand   = (state == ST_EXPAND);
  assign word_acc = i_word_valid & word_ready & ~i_abort;
  assign w_hs     = expand & i_w_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (word_acc) state_nxt = ST_LOAD;
      ST_LOAD:   if (word_acc && load_cnt == 4'd15) state_nxt = ST_EXPAND;
      ST_EXPAND: if (w_hs && round == LAST_ROUND) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (i_abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Ready is registered so every output is zero in the first cycle after reset or abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_ready <= 1'b0;
      load_cnt   <= '0;
      round      <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      word_ready <= ~i_abort & ((state_nxt == ST_IDLE) | (state_nxt == ST_LOAD));
      if (i_abort) begin
        load_cnt <= '0;
        round    <= '0;
      end else begin
        if (word_acc) begin
          win[load_cnt] <= i_word;
          load_cnt      <= load_cnt + 4'd1;
        end
        if (w_hs) begin
          for (int i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15] <= w_next;
          round   <= (round == LAST_ROUND) ? 7'd0 : round + 7'd1;
        end
      end
    end
  end

  assign o_word_ready = word_ready;
  assign o_w_valid    = expand;
  assign o_w          = expand ? win[0] : '0;
  assign o_round      = round;
  assign o_FSM_state  = state;
  assign o_done       = (state == ST_DONE);

endmodule
